// File: rtl/pcs_block_sync_rx_if.sv
// Gearbox-to-block-sync link: header stream in, slip/lock/header-valid status back.
interface pcs_block_sync_rx_if #(
    parameter int HEAD_W = 2
);
    logic              signal_ok_i;
    logic              valid_i;
    logic [HEAD_W-1:0] head_i;
    logic              slip_v_o;
    logic              lock_v_o;
    logic              head_v_o;

    // Gearbox / PMA side drives the header stream and consumes slip and lock status.
    modport master (
        output signal_ok_i, valid_i, head_i,
        input  slip_v_o, lock_v_o, head_v_o
    );

    modport slave (
        input  signal_ok_i, valid_i, head_i,
        output slip_v_o, lock_v_o, head_v_o
    );
endinterface

// File: rtl/pcs_block_sync_rx.sv
// 64b/66b block lock FSM: hunts sync-header alignment by slipping the gearbox
// one bit at a time, then monitors header error density while locked.
module pcs_block_sync_rx #(
    parameter int HEAD_W      = 2,
    parameter int SH_CNT_MAX  = 64,
    parameter int SH_INV_MAX  = 16,
    parameter int SLIP_WAIT_N = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    pcs_block_sync_rx_if.slave    rx
);
    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W  = $clog2(SH_INV_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT_N > 0) ? $clog2(SLIP_WAIT_N + 1) : 1;

    typedef enum logic [2:0] {
        INIT,
        TEST,
        LOCKED,
        SLIP,
        WAIT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  sh_cnt;
    logic [INV_W-1:0]  sh_inv_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              slip;
    logic              lock;

    logic              hdr_ok;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [INV_W-1:0]  inv_nxt;
    logic              win_end;
    logic              inv_lim;

    // Counters saturate at their terminal value so they can never wrap.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(SH_CNT_MAX))
            return CNT_W'(SH_CNT_MAX);
        return c + CNT_W'(1);
    endfunction

    function automatic logic [INV_W-1:0] sat_inv(input logic [INV_W-1:0] c, input logic bad);
        if (!bad)
            return c;
        if (c >= INV_W'(SH_INV_MAX))
            return INV_W'(SH_INV_MAX);
        return c + INV_W'(1);
    endfunction

    assign hdr_ok      = rx.head_i[1] ^ rx.head_i[0];
    assign rx.head_v_o = rx.valid_i & hdr_ok;
    assign rx.slip_v_o = slip;
    assign rx.lock_v_o = lock;

    always_comb begin
        cnt_nxt = sat_cnt(sh_cnt);
        inv_nxt = sat_inv(sh_inv_cnt, !hdr_ok);
        win_end = (cnt_nxt == CNT_W'(SH_CNT_MAX));
        inv_lim = (inv_nxt == INV_W'(SH_INV_MAX));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= INIT;
            sh_cnt     <= '0;
            sh_inv_cnt <= '0;
            wait_cnt   <= '0;
            slip       <= 1'b0;
            lock       <= 1'b0;
        end else if (!rx.signal_ok_i) begin
            // Signal loss overrides everything, including a slip that would fire this beat.
            state      <= INIT;
            sh_cnt     <= '0;
            sh_inv_cnt <= '0;
            wait_cnt   <= '0;
            slip       <= 1'b0;
            lock       <= 1'b0;
        end else begin
            slip <= 1'b0;
            case (state)
                INIT: begin
                    sh_cnt     <= '0;
                    sh_inv_cnt <= '0;
                    lock       <= 1'b0;
                    state      <= TEST;
                end
                TEST: begin
                    if (rx.valid_i) begin
                        if (!hdr_ok) begin
                            state      <= SLIP;
                            slip       <= 1'b1;
                            sh_cnt     <= '0;
                            sh_inv_cnt <= '0;
                        end else if (win_end) begin
                            state      <= LOCKED;
                            lock       <= 1'b1;
                            sh_cnt     <= '0;
                            sh_inv_cnt <= '0;
                        end else begin
                            sh_cnt <= cnt_nxt;
                        end
                    end
                end
                LOCKED: begin
                    // Error limit is checked before window end so a collision slips.
                    if (rx.valid_i) begin
                        if (inv_lim) begin
                            state      <= SLIP;
                            slip       <= 1'b1;
                            lock       <= 1'b0;
                            sh_cnt     <= '0;
                            sh_inv_cnt <= '0;
                        end else if (win_end) begin
                            sh_cnt     <= '0;
                            sh_inv_cnt <= '0;
                        end else begin
                            sh_cnt     <= cnt_nxt;
                            sh_inv_cnt <= inv_nxt;
                        end
                    end
                end
                SLIP: begin
                    sh_cnt     <= '0;
                    sh_inv_cnt <= '0;
                    wait_cnt   <= WAIT_W'(SLIP_WAIT_N);
                    state      <= WAIT;
                end
                WAIT: begin
                    // Headers during the gearbox realignment are discarded unseen.
                    if (wait_cnt == '0) begin
                        state <= TEST;
                    end else if (rx.valid_i) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(1))
                            state <= TEST;
                    end
                end
                default: begin
                    state <= INIT;
                    lock  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcs_block_sync_rx.sv
// Directed bench for pcs_block_sync_rx: acquisition, slip, error tolerance,
// lock loss, boundary collision, signal loss and async reset.
module tb_pcs_block_sync_rx;
    logic clk;
    logic nreset;
    int   checks = 0;
    int   errors = 0;
    int   slips  = 0;
    logic prev_slip = 1'b0;
    logic tog = 1'b0;

    pcs_block_sync_rx_if #(.HEAD_W(2)) rx ();

    pcs_block_sync_rx #(
        .HEAD_W(2), .SH_CNT_MAX(64), .SH_INV_MAX(16), .SLIP_WAIT_N(2)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .rx(rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic v, input logic [1:0] h);
        rx.valid_i = v;
        rx.head_i  = h;
        @(posedge clk);
        #1;
        if (rx.slip_v_o === 1'b1)
            slips++;
        checks++;
        assert (!(rx.slip_v_o && rx.lock_v_o) && !(rx.slip_v_o && prev_slip)) else begin
            errors++;
            $error("FAIL invariant observed slip=%b lock=%b prev_slip=%b expected no overlap",
                   rx.slip_v_o, rx.lock_v_o, prev_slip);
        end
        prev_slip = rx.slip_v_o;
    endtask

    task automatic good(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, tog ? 2'b10 : 2'b01);
            tog = ~tog;
        end
    endtask

    task automatic bad(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, tog ? 2'b11 : 2'b00);
            tog = ~tog;
        end
    endtask

    initial begin
        nreset         = 1'b0;
        rx.signal_ok_i = 1'b0;
        rx.valid_i     = 1'b0;
        rx.head_i      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_lock", rx.lock_v_o, 0);
        chk("reset_slip", rx.slip_v_o, 0);

        rx.valid_i = 1'b1; rx.head_i = 2'b11; #1;
        chk("head_v_11", rx.head_v_o, 0);
        rx.head_i = 2'b01; #1;
        chk("head_v_01", rx.head_v_o, 1);
        rx.head_i = 2'b10; #1;
        chk("head_v_10", rx.head_v_o, 1);
        rx.valid_i = 1'b0; #1;
        chk("head_v_gated", rx.head_v_o, 0);

        nreset = 1'b1;
        step(1'b0, 2'b00);
        chk("init_hold_lock", rx.lock_v_o, 0);
        rx.signal_ok_i = 1'b1;
        step(1'b0, 2'b00);

        // Lock acquisition
        good(63);
        chk("acq_no_lock_63", rx.lock_v_o, 0);
        good(1);
        chk("acq_lock_64", rx.lock_v_o, 1);
        chk("acq_no_slip", slips, 0);

        // Hold lock with 15 errors (even beats 2..30), with valid gaps mid-window
        for (int i = 1; i <= 64; i++) begin
            if (i == 21) begin
                repeat (3) step(1'b0, 2'b00);
            end
            if ((i % 2 == 0) && (i <= 30)) bad(1);
            else good(1);
        end
        chk("hold_lock_w1", rx.lock_v_o, 1);
        chk("hold_no_slip_w1", slips, 0);
        bad(15);
        chk("hold_lock_w2_cleared", rx.lock_v_o, 1);
        chk("hold_no_slip_w2", slips, 0);
        good(49);
        chk("hold_lock_w2_end", rx.lock_v_o, 1);

        // Lose lock: invalid beats 25..40
        good(24);
        bad(15);
        chk("lose_lock_39", rx.lock_v_o, 1);
        chk("lose_slip_39", rx.slip_v_o, 0);
        bad(1);
        chk("lose_slip_40", rx.slip_v_o, 1);
        chk("lose_lock_40", rx.lock_v_o, 0);
        step(1'b0, 2'b00);
        chk("lose_slip_one_cycle", rx.slip_v_o, 0);
        step(1'b1, 2'b11);
        chk("lose_wait1_no_slip", rx.slip_v_o, 0);
        step(1'b1, 2'b11);
        chk("lose_wait2_no_slip", rx.slip_v_o, 0);

        // Unlocked slip: 10 good then 00 on beat 11
        good(10);
        chk("unl_slip_10", rx.slip_v_o, 0);
        step(1'b1, 2'b00);
        chk("unl_slip_11", rx.slip_v_o, 1);
        step(1'b0, 2'b00);
        chk("unl_slip_clear", rx.slip_v_o, 0);
        step(1'b1, 2'b11);
        chk("unl_wait1", rx.slip_v_o, 0);
        step(1'b1, 2'b11);
        chk("unl_wait2", rx.slip_v_o, 0);
        good(63);
        chk("unl_relock_63", rx.lock_v_o, 0);
        good(1);
        chk("unl_relock_64", rx.lock_v_o, 1);
        chk("slip_count_2", slips, 2);

        // Boundary collision: 15 invalid at 49..63, 16th on beat 64
        good(48);
        bad(15);
        chk("coll_lock_63", rx.lock_v_o, 1);
        chk("coll_slip_63", rx.slip_v_o, 0);
        bad(1);
        chk("coll_slip_64", rx.slip_v_o, 1);
        chk("coll_lock_64", rx.lock_v_o, 0);
        step(1'b0, 2'b00);
        chk("coll_lock_after", rx.lock_v_o, 0);
        good(2);
        chk("coll_wait_lock", rx.lock_v_o, 0);
        good(63);
        chk("coll_relock_63", rx.lock_v_o, 0);
        good(1);
        chk("coll_relock_64", rx.lock_v_o, 1);
        chk("slip_count_3", slips, 3);

        // Signal loss on the beat that would otherwise be the 16th error
        bad(15);
        chk("sig_pending_lock", rx.lock_v_o, 1);
        rx.signal_ok_i = 1'b0;
        step(1'b1, 2'b00);
        chk("sig_pending_no_slip", rx.slip_v_o, 0);
        chk("sig_pending_lock0", rx.lock_v_o, 0);
        repeat (4) step(1'b1, 2'b01);
        chk("sig_low_hold", rx.lock_v_o, 0);
        chk("slip_count_sig", slips, 3);
        rx.signal_ok_i = 1'b1;
        step(1'b0, 2'b00);
        good(64);
        chk("sig_relock_a", rx.lock_v_o, 1);

        // Signal loss while locked with valid gaps
        good(10);
        repeat (3) step(1'b0, 2'b00);
        chk("gap_lock_hold", rx.lock_v_o, 1);
        rx.signal_ok_i = 1'b0;
        step(1'b0, 2'b00);
        chk("gap_sig_lock0", rx.lock_v_o, 0);
        chk("gap_sig_slip0", rx.slip_v_o, 0);
        repeat (4) step(1'b0, 2'b00);
        rx.signal_ok_i = 1'b1;
        step(1'b0, 2'b00);
        good(63);
        chk("gap_relock_63", rx.lock_v_o, 0);
        good(1);
        chk("gap_relock_64", rx.lock_v_o, 1);

        // Async reset mid-window while locked
        good(20);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_lock", rx.lock_v_o, 0);
        chk("arst_slip", rx.slip_v_o, 0);
        step(1'b1, 2'b01);
        step(1'b1, 2'b01);
        chk("arst_held_lock", rx.lock_v_o, 0);
        nreset = 1'b1;
        step(1'b0, 2'b00);

        // Reset again partway through an unlocked window: count must restart
        good(30);
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        step(1'b0, 2'b00);
        good(63);
        chk("arst_relock_63", rx.lock_v_o, 0);
        good(1);
        chk("arst_relock_64", rx.lock_v_o, 1);
        chk("slip_count_final", slips, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
